// File: rtl/xlr8_wdt_pkg.sv
// Shared constants and the timeout-limit helper for the XLR8 watchdog.
package xlr8_wdt_pkg;

    localparam int WDIF_BIT = 7;
    localparam int WDIE_BIT = 6;
    localparam int WDP3_BIT = 5;
    localparam int WDCE_BIT = 4;
    localparam int WDE_BIT  = 3;

    localparam logic [3:0] WDP_MAX = 4'd9;
    localparam int LIMIT_WIDTH = 21;
    localparam logic [LIMIT_WIDTH-1:0] BASE_LIMIT = 21'd2048;

    // Prescaler values above WDP_MAX alias to the longest timeout.
    function automatic logic [LIMIT_WIDTH-1:0] wdt_limit(input logic [3:0] wdp);
        logic [3:0] shamt;
        shamt = (wdp > WDP_MAX) ? WDP_MAX : wdp;
        return BASE_LIMIT << shamt;
    endfunction

endpackage

// File: rtl/xlr8_wdt_prescaler.sv
// Watchdog tick counter: counts en128khz ticks and pulses timeout at the selected limit.
module xlr8_wdt_prescaler
    import xlr8_wdt_pkg::*;
#(
    parameter int CNT_WIDTH = 20
) (
    input  logic       clk,
    input  logic       core_rstn,
    input  logic       run,
    input  logic       tick,
    input  logic       wdr,
    input  logic [3:0] wdp,
    output logic       timeout
);

    logic [CNT_WIDTH-1:0]   cnt;
    logic [LIMIT_WIDTH-1:0] limit;
    logic                   at_limit;

    assign limit = wdt_limit(wdp);
    // >= rather than == so that lowering WDP below the count times out on the next tick.
    assign at_limit = LIMIT_WIDTH'(cnt) >= (limit - LIMIT_WIDTH'(1));
    assign timeout  = run && tick && !wdr && at_limit;

    always_ff @(posedge clk or negedge core_rstn) begin
        if (!core_rstn) begin
            cnt <= '0;
        end else if (!run || wdr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= timeout ? '0 : cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/xlr8_wdt.sv
// AVR-compatible watchdog (WDTCSR): register access, timed change window and mode actions.
module xlr8_wdt
    import xlr8_wdt_pkg::*;
#(
    parameter logic [7:0] WDTCSR_ADDR = 8'h60,
    parameter int         CNT_WIDTH   = 20
) (
    input  logic       clk,
    input  logic       core_rstn,
    input  logic       en128khz,
    input  logic [7:0] ramadr,
    input  logic       ramre,
    input  logic       ramwe,
    input  logic       dm_sel,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       io_out_en,
    input  logic       wdr,
    input  logic       wdrf,
    output logic       wdt_irq,
    input  logic       wdt_irq_ack,
    output logic       wdt_rst_req
);

    logic       sel, we, re;
    logic       wdif, wdie, wdce, wde, rst_req;
    logic [3:0] wdp;
    logic [1:0] win_cnt;
    logic       wde_eff, run, timeout;
    logic       wdif_nxt, wdie_nxt, rst_nxt;
    logic [7:0] wdtcsr;

    assign sel       = dm_sel && (ramadr == WDTCSR_ADDR);
    assign we        = sel && ramwe;
    assign re        = sel && ramre;
    assign io_out_en = re;

    assign wde_eff = wde | wdrf;
    assign run     = wde_eff | wdie;
    assign wdtcsr  = {wdif, wdie, wdp[3], wdce, wde_eff, wdp[2:0]};
    assign dbus_out    = {8{sel}} & wdtcsr;
    assign wdt_irq     = wdif & wdie;
    assign wdt_rst_req = rst_req;

    xlr8_wdt_prescaler #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_prescaler (
        .clk       (clk),
        .core_rstn (core_rstn),
        .run       (run),
        .tick      (en128khz),
        .wdr       (wdr),
        .wdp       (wdp),
        .timeout   (timeout)
    );

    // Flag updates; a hardware timeout is applied last so it wins over clears.
    always_comb begin
        wdif_nxt = wdif;
        wdie_nxt = wdie;
        rst_nxt  = rst_req;
        if (we) begin
            wdie_nxt = dbus_in[WDIE_BIT];
            if (dbus_in[WDIF_BIT]) wdif_nxt = 1'b0;
        end
        if (wdt_irq_ack) begin
            wdif_nxt = 1'b0;
            if (wde_eff && wdie) wdie_nxt = 1'b0;
        end
        if (timeout) begin
            if (wdie && (!wde_eff || !wdif)) wdif_nxt = 1'b1;
            if (wde_eff && (!wdie || wdif)) rst_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge core_rstn) begin
        if (!core_rstn) begin
            wdif    <= 1'b0;
            wdie    <= 1'b0;
            wdce    <= 1'b0;
            wde     <= 1'b0;
            wdp     <= '0;
            win_cnt <= '0;
            rst_req <= 1'b0;
        end else begin
            wdif    <= wdif_nxt;
            wdie    <= wdie_nxt;
            rst_req <= rst_nxt;
            if (we && wdce) begin
                // Any write inside the window consumes it.
                wdce    <= 1'b0;
                win_cnt <= '0;
                wde     <= dbus_in[WDE_BIT];
                wdp     <= {dbus_in[WDP3_BIT], dbus_in[2:0]};
            end else begin
                if (we && dbus_in[WDCE_BIT] && dbus_in[WDE_BIT]) begin
                    wdce    <= 1'b1;
                    win_cnt <= 2'd3;
                end else if (wdce) begin
                    win_cnt <= win_cnt - 2'd1;
                    if (win_cnt == 2'd1) wdce <= 1'b0;
                end
                if (we && dbus_in[WDE_BIT]) wde <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xlr8_wdt.sv
// Self-checking bench for xlr8_wdt: directed scenarios plus randomized traffic against a reference model.
module tb_xlr8_wdt;

    logic       clk = 1'b0;
    logic       core_rstn = 1'b0;
    logic       en128khz = 1'b0;
    logic [7:0] ramadr = 8'h60;
    logic       ramre = 1'b1;
    logic       ramwe = 1'b0;
    logic       dm_sel = 1'b1;
    logic [7:0] dbus_in = 8'h00;
    logic [7:0] dbus_out;
    logic       io_out_en;
    logic       wdr = 1'b0;
    logic       wdrf = 1'b0;
    logic       wdt_irq;
    logic       wdt_irq_ack = 1'b0;
    logic       wdt_rst_req;

    int n_checks = 0;
    int n_fail = 0;

    xlr8_wdt dut (
        .clk         (clk),
        .core_rstn   (core_rstn),
        .en128khz    (en128khz),
        .ramadr      (ramadr),
        .ramre       (ramre),
        .ramwe       (ramwe),
        .dm_sel      (dm_sel),
        .dbus_in     (dbus_in),
        .dbus_out    (dbus_out),
        .io_out_en   (io_out_en),
        .wdr         (wdr),
        .wdrf        (wdrf),
        .wdt_irq     (wdt_irq),
        .wdt_irq_ack (wdt_irq_ack),
        .wdt_rst_req (wdt_rst_req)
    );

    always #5 clk = ~clk;

    // Reference model: window tracked as an absolute cycle deadline, timeout as 2048*2^min(WDP,9).
    typedef struct {
        int     cnt;
        bit     wdif;
        bit     wdie;
        bit     wde;
        bit     rst;
        int     wdp;
        longint n;
        longint win_close;
    } model_t;

    model_t m;

    function automatic model_t model_zero();
        model_t r;
        r.cnt = 0; r.wdif = 0; r.wdie = 0; r.wde = 0; r.rst = 0;
        r.wdp = 0; r.n = 0; r.win_close = 0;
        return r;
    endfunction

    function automatic model_t model_next(model_t s);
        model_t r;
        bit wr, wde_eff, running, to, in_win;
        int lim;
        r = s;
        wr = dm_sel && (ramadr == 8'h60) && ramwe;
        wde_eff = s.wde || wdrf;
        running = wde_eff || s.wdie;
        lim = 2048 * (1 << ((s.wdp > 9) ? 9 : s.wdp));
        to = running && en128khz && !wdr && (s.cnt >= lim - 1);
        if (!running || wdr) r.cnt = 0;
        else if (en128khz) r.cnt = to ? 0 : s.cnt + 1;
        in_win = s.n < s.win_close;
        if (wr) begin
            if (in_win) begin
                r.wde = dbus_in[3];
                r.wdp = dbus_in[5] * 8 + dbus_in[2:0];
                r.win_close = s.n + 1;
            end else begin
                if (dbus_in[4] && dbus_in[3]) r.win_close = s.n + 4;
                if (dbus_in[3]) r.wde = 1;
            end
            r.wdie = dbus_in[6];
            if (dbus_in[7]) r.wdif = 0;
        end
        if (wdt_irq_ack) begin
            r.wdif = 0;
            if (wde_eff && s.wdie) r.wdie = 0;
        end
        if (to) begin
            if (wde_eff && s.wdie) begin
                if (s.wdif) r.rst = 1;
                else r.wdif = 1;
            end else if (s.wdie) begin
                r.wdif = 1;
            end else begin
                r.rst = 1;
            end
        end
        r.n = s.n + 1;
        return r;
    endfunction

    function automatic logic [7:0] model_csr();
        logic [3:0] p;
        p = 4'(m.wdp);
        return {m.wdif, m.wdie, p[3], (m.n < m.win_close), (m.wde | wdrf), p[2:0]};
    endfunction

    always @(posedge clk or negedge core_rstn) begin
        if (!core_rstn) m <= model_zero();
        else m <= model_next(m);
    end

    // Drivers
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_defaults();
        en128khz = 0; ramadr = 8'h60; ramre = 1; ramwe = 0; dm_sel = 1;
        dbus_in = 8'h00; wdr = 0; wdt_irq_ack = 0; wdrf = 0;
    endtask

    task automatic apply_reset();
        set_defaults();
        core_rstn = 0;
        step();
        core_rstn = 1;
        step();
    endtask

    task automatic write_reg(input logic [7:0] d);
        ramwe = 1; dbus_in = d;
        step();
        ramwe = 0; dbus_in = 8'h00;
    endtask

    task automatic tick_n(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            en128khz = 1;
            step();
            en128khz = 0;
            for (int j = 1; j < gap; j++) step();
        end
    endtask

    task automatic pulse_wdr();
        wdr = 1; step(); wdr = 0;
    endtask

    task automatic pulse_ack();
        wdt_irq_ack = 1; step(); wdt_irq_ack = 0;
    endtask

    // Scenarios
    task automatic test_reset();
        set_defaults();
        core_rstn = 0;
        step();
        n_checks++; if (dbus_out !== 8'h00) begin n_fail++; $display("FAIL reset_dbus: got %h want 00", dbus_out); end
        n_checks++; if (io_out_en !== 1'b1) begin n_fail++; $display("FAIL reset_io_out_en: got %b want 1", io_out_en); end
        n_checks++; if (wdt_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", wdt_irq); end
        n_checks++; if (wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL reset_rst_req: got %b want 0", wdt_rst_req); end
        core_rstn = 1;
        tick_n(3000, 1);
        n_checks++; if (wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL stopped_no_rst: got %b want 0", wdt_rst_req); end
    endtask

    task automatic test_interrupt();
        apply_reset();
        write_reg(8'h40);
        n_checks++; if (dbus_out !== 8'h40) begin n_fail++; $display("FAIL irq_wr_readback: got %h want 40", dbus_out); end
        tick_n(2047, 4);
        n_checks++; if (wdt_irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b want 0", wdt_irq); end
        tick_n(1, 1);
        n_checks++; if (wdt_irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b want 1", wdt_irq); end
        n_checks++; if (dbus_out !== 8'hC0) begin n_fail++; $display("FAIL irq_readback: got %h want C0", dbus_out); end
        n_checks++; if (wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL irq_no_rst: got %b want 0", wdt_rst_req); end
        dm_sel = 0; #1;
        n_checks++; if (dbus_out !== 8'h00 || io_out_en !== 1'b0) begin n_fail++; $display("FAIL unselected: got %h/%b want 00/0", dbus_out, io_out_en); end
        dm_sel = 1; ramadr = 8'h61; #1;
        n_checks++; if (dbus_out !== 8'h00) begin n_fail++; $display("FAIL wrong_addr: got %h want 00", dbus_out); end
        ramadr = 8'h60; ramre = 0; #1;
        n_checks++; if (io_out_en !== 1'b0 || dbus_out !== 8'hC0) begin n_fail++; $display("FAIL no_read: got %b/%h want 0/C0", io_out_en, dbus_out); end
        ramre = 1;
        write_reg(8'h80);
        n_checks++; if (wdt_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear_w1: got %b want 0", wdt_irq); end
        n_checks++; if (dbus_out !== 8'h00) begin n_fail++; $display("FAIL irq_clear_readback: got %h want 00", dbus_out); end
    endtask

    task automatic test_reset_mode();
        apply_reset();
        write_reg(8'h08);
        tick_n(2000, 1);
        pulse_wdr();
        tick_n(48, 1);
        n_checks++; if (wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL wdr_defers: got %b want 0", wdt_rst_req); end
        tick_n(1999, 1);
        n_checks++; if (wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL rst_early: got %b want 0", wdt_rst_req); end
        tick_n(1, 1);
        n_checks++; if (wdt_rst_req !== 1'b1) begin n_fail++; $display("FAIL rst_at_4048: got %b want 1", wdt_rst_req); end
        tick_n(3000, 1);
        n_checks++; if (wdt_rst_req !== 1'b1) begin n_fail++; $display("FAIL rst_holds: got %b want 1", wdt_rst_req); end
        n_checks++; if (dbus_out !== 8'h08) begin n_fail++; $display("FAIL rst_readback: got %h want 08", dbus_out); end
        #2 core_rstn = 0; #1;
        n_checks++; if (wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL rst_async_clear: got %b want 0", wdt_rst_req); end
        core_rstn = 1;
        step();
    endtask

    task automatic test_timed_seq();
        apply_reset();
        write_reg(8'h08);
        write_reg(8'h18);
        n_checks++; if (dbus_out !== 8'h18) begin n_fail++; $display("FAIL window_open: got %h want 18", dbus_out); end
        step(); step();
        write_reg(8'h01);
        n_checks++; if (dbus_out !== 8'h01) begin n_fail++; $display("FAIL window_change: got %h want 01", dbus_out); end
        write_reg(8'h18);
        n_checks++; if (dbus_out !== 8'h19) begin n_fail++; $display("FAIL window_reopen: got %h want 19", dbus_out); end
        write_reg(8'h08);
        write_reg(8'h00);
        n_checks++; if (dbus_out !== 8'h08) begin n_fail++; $display("FAIL window_consumed: got %h want 08", dbus_out); end
        write_reg(8'h18);
        step();
        n_checks++; if (dbus_out !== 8'h18) begin n_fail++; $display("FAIL window_mid: got %h want 18", dbus_out); end
        step(); step();
        n_checks++; if (dbus_out !== 8'h08) begin n_fail++; $display("FAIL window_expired: got %h want 08", dbus_out); end
        write_reg(8'h01);
        n_checks++; if (dbus_out !== 8'h08) begin n_fail++; $display("FAIL late_write: got %h want 08", dbus_out); end
        write_reg(8'h48);
        n_checks++; if (dbus_out !== 8'h48) begin n_fail++; $display("FAIL wdie_free: got %h want 48", dbus_out); end
    endtask

    task automatic test_irq_then_reset();
        apply_reset();
        write_reg(8'h48);
        tick_n(2047, 1);
        n_checks++; if (wdt_irq !== 1'b0) begin n_fail++; $display("FAIL ir_early: got %b want 0", wdt_irq); end
        tick_n(1, 1);
        n_checks++; if (wdt_irq !== 1'b1) begin n_fail++; $display("FAIL ir_irq: got %b want 1", wdt_irq); end
        n_checks++; if (dbus_out !== 8'hC8) begin n_fail++; $display("FAIL ir_readback: got %h want C8", dbus_out); end
        pulse_ack();
        n_checks++; if (dbus_out !== 8'h08 || wdt_irq !== 1'b0) begin n_fail++; $display("FAIL ir_ack: got %h/%b want 08/0", dbus_out, wdt_irq); end
        tick_n(2047, 1);
        n_checks++; if (wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL ir_rst_early: got %b want 0", wdt_rst_req); end
        tick_n(1, 1);
        n_checks++; if (wdt_rst_req !== 1'b1) begin n_fail++; $display("FAIL ir_rst_4096: got %b want 1", wdt_rst_req); end
        apply_reset();
        write_reg(8'h48);
        tick_n(2048, 1);
        n_checks++; if (wdt_irq !== 1'b1 || wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL noack_first: got %b/%b want 1/0", wdt_irq, wdt_rst_req); end
        tick_n(2048, 1);
        n_checks++; if (wdt_rst_req !== 1'b1) begin n_fail++; $display("FAIL noack_rst: got %b want 1", wdt_rst_req); end
    endtask

    task automatic test_wdrf();
        apply_reset();
        wdrf = 1;
        step();
        n_checks++; if (dbus_out !== 8'h08) begin n_fail++; $display("FAIL wdrf_readback: got %h want 08", dbus_out); end
        tick_n(2047, 1);
        n_checks++; if (wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL wdrf_early: got %b want 0", wdt_rst_req); end
        tick_n(1, 1);
        n_checks++; if (wdt_rst_req !== 1'b1) begin n_fail++; $display("FAIL wdrf_rst: got %b want 1", wdt_rst_req); end
        write_reg(8'h18);
        write_reg(8'h00);
        n_checks++; if (dbus_out !== 8'h08) begin n_fail++; $display("FAIL wdrf_forced: got %h want 08", dbus_out); end
        wdrf = 0; #1;
        n_checks++; if (dbus_out !== 8'h00) begin n_fail++; $display("FAIL wdrf_release: got %h want 00", dbus_out); end
    endtask

    task automatic test_wdp();
        apply_reset();
        write_reg(8'h18);
        write_reg(8'h09);
        tick_n(4095, 1);
        n_checks++; if (wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL wdp1_early: got %b want 0", wdt_rst_req); end
        tick_n(1, 1);
        n_checks++; if (wdt_rst_req !== 1'b1) begin n_fail++; $display("FAIL wdp1_rst: got %b want 1", wdt_rst_req); end
        apply_reset();
        write_reg(8'h18);
        write_reg(8'h2F);
        n_checks++; if (dbus_out !== 8'h2F) begin n_fail++; $display("FAIL wdpf_readback: got %h want 2F", dbus_out); end
        tick_n(20000, 1);
        n_checks++; if (wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL wdpf_long: got %b want 0", wdt_rst_req); end
        write_reg(8'h18);
        write_reg(8'h08);
        n_checks++; if (dbus_out !== 8'h08 || wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL wdp_lower: got %h/%b want 08/0", dbus_out, wdt_rst_req); end
        tick_n(1, 1);
        n_checks++; if (wdt_rst_req !== 1'b1) begin n_fail++; $display("FAIL wdp_lower_force: got %b want 1", wdt_rst_req); end
    endtask

    task automatic test_random();
        int pend_gap;
        logic [7:0] exp_out;
        logic exp_en;
        bit s;
        pend_gap = 0;
        apply_reset();
        write_reg(8'h48);
        for (int c = 0; c < 12000; c++) begin
            en128khz = ($urandom_range(3, 0) != 0);
            wdr = ($urandom_range(599, 0) == 0);
            wdt_irq_ack = ($urandom_range(199, 0) == 0);
            if ($urandom_range(1999, 0) == 0) wdrf = ~wdrf;
            dm_sel = ($urandom_range(9, 0) != 0);
            ramadr = ($urandom_range(19, 0) == 0) ? 8'h61 : 8'h60;
            ramre = 1'($urandom_range(1, 0));
            ramwe = 0;
            if (pend_gap > 0) begin
                pend_gap--;
                if (pend_gap == 0) begin
                    ramwe = 1;
                    dbus_in = 8'($urandom) & 8'hD9;
                end
            end else if ($urandom_range(299, 0) == 0) begin
                ramwe = 1;
                dbus_in = 8'($urandom);
                if ($urandom_range(1, 0) == 1) begin
                    dbus_in[4:3] = 2'b11;
                    pend_gap = $urandom_range(5, 1);
                end
            end
            if (c == 6000) begin
                #2 core_rstn = 0; #1;
                n_checks++; if (wdt_irq !== 1'b0 || wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL rnd_async_reset: got %b/%b want 0/0", wdt_irq, wdt_rst_req); end
                #1 core_rstn = 1;
            end
            step();
            s = dm_sel && (ramadr == 8'h60);
            exp_out = s ? model_csr() : 8'h00;
            exp_en = s && ramre;
            n_checks++; if (dbus_out !== exp_out) begin n_fail++; $display("FAIL rnd_dbus c=%0d: got %h want %h", c, dbus_out, exp_out); end
            n_checks++; if (io_out_en !== exp_en) begin n_fail++; $display("FAIL rnd_io_out_en c=%0d: got %b want %b", c, io_out_en, exp_en); end
            n_checks++; if (wdt_irq !== (m.wdif && m.wdie)) begin n_fail++; $display("FAIL rnd_irq c=%0d: got %b want %b", c, wdt_irq, m.wdif && m.wdie); end
            n_checks++; if (wdt_rst_req !== m.rst) begin n_fail++; $display("FAIL rnd_rst_req c=%0d: got %b want %b", c, wdt_rst_req, m.rst); end
        end
        set_defaults();
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_reset_mode();
        test_timed_seq();
        test_irq_then_reset();
        test_wdrf();
        test_wdp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
